// File: rtl/dense_seq_ctrl.sv
// dense_seq_ctrl: serial dense-layer sequencer.
// One MAC is time-shared across all output classes. Weights and biases are
// streamed from an external synchronous memory (one word per cycle, data
// returns one cycle after the address). Each class score is accumulated
// serially. When all scores are in, a one-hot argmax is emitted in which
// every tied maximum is flagged.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for a feature vector, in_ready=1
// RUN   | streaming N_OUT*WPC memory reads and accumulating scores
// CMP   | one cycle: build tie-aware one-hot from stored scores
// DONE  | result held on outputs until out_ready
module dense_seq_ctrl #(
    parameter int N_IN  = 20,
    parameter int N_OUT = 10,
    parameter int X_W   = 6,
    parameter int W_W   = 8,
    parameter int ACC_W = 19,
    localparam int WPC    = N_IN + 1,
    localparam int TOTAL  = N_OUT * WPC,
    localparam int ADDR_W = $clog2(TOTAL),
    localparam int IDX_W  = $clog2(N_OUT)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [N_IN*X_W-1:0]    x_flat,
    output logic                   w_en,
    output logic [ADDR_W-1:0]      w_addr,
    input  logic [W_W-1:0]         w_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [N_OUT-1:0]       y,
    output logic [IDX_W-1:0]       class_idx,
    output logic [ACC_W-1:0]       max_score,
    output logic                   busy
);

    localparam int KW = $clog2(WPC);
    localparam logic [KW-1:0]     K_BIAS    = KW'(N_IN);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(N_OUT - 1);
    localparam logic [ADDR_W-1:0] READS_M1  = ADDR_W'(TOTAL - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        CMP  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                   state;
    logic [N_IN*X_W-1:0]      x_reg;

    // Issue side: down-counter of reads still to launch after the current one,
    // plus the (class, k) tag of the address being presented.
    logic [ADDR_W-1:0]        rem;
    logic [KW-1:0]            iss_k;
    logic [IDX_W-1:0]         iss_cls;

    // Return side: tag of the word arriving on w_data this cycle.
    logic                     rd_vld;
    logic [KW-1:0]            rd_k;
    logic [IDX_W-1:0]         rd_cls;

    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  run_max;
    logic [IDX_W-1:0]         run_idx;
    logic signed [ACC_W-1:0]  score [N_OUT];

    // Feature vector padded with one zero slot so the bias tag (k == N_IN)
    // selects a defined value instead of running off the end.
    logic [WPC*X_W-1:0]       x_pad;
    logic [X_W-1:0]           xk;
    logic signed [ACC_W-1:0]  x_ext;
    logic signed [ACC_W-1:0]  w_ext;
    logic signed [ACC_W-1:0]  prod;
    logic signed [ACC_W-1:0]  mac_val;
    logic signed [ACC_W-1:0]  score_val;

    assign x_pad = {{X_W{1'b0}}, x_reg};

    // MAC datapath: unsigned feature times signed weight, all in ACC_W bits
    // so the sum wraps modulo 2^ACC_W.
    always_comb begin
        xk        = x_pad[int'(rd_k)*X_W +: X_W];
        x_ext     = {{(ACC_W-X_W){1'b0}}, xk};
        w_ext     = {{(ACC_W-W_W){w_data[W_W-1]}}, w_data};
        prod      = x_ext * w_ext;
        mac_val   = (rd_k == '0) ? prod : (acc + prod);
        score_val = acc + w_ext;
    end

    // Sequencer FSM with registered outputs, read pipeline and accumulator.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            x_reg     <= '0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            w_en      <= 1'b0;
            w_addr    <= '0;
            rem       <= '0;
            iss_k     <= '0;
            iss_cls   <= '0;
            rd_vld    <= 1'b0;
            rd_k      <= '0;
            rd_cls    <= '0;
            acc       <= '0;
            run_max   <= '0;
            run_idx   <= '0;
            out_valid <= 1'b0;
            y         <= '0;
            class_idx <= '0;
            max_score <= '0;
            for (int c = 0; c < N_OUT; c++) begin
                score[c] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    rd_vld <= 1'b0;
                    if (in_valid && in_ready) begin
                        x_reg    <= x_flat;
                        state    <= RUN;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        w_en     <= 1'b1;
                        w_addr   <= '0;
                        rem      <= READS_M1;
                        iss_k    <= '0;
                        iss_cls  <= '0;
                    end
                end

                RUN: begin
                    // Tag travels one cycle behind the address, matching
                    // the memory read latency.
                    rd_vld <= w_en;
                    rd_k   <= iss_k;
                    rd_cls <= iss_cls;

                    if (w_en) begin
                        if (iss_k == K_BIAS) begin
                            iss_k   <= '0;
                            iss_cls <= iss_cls + 1'b1;
                        end else begin
                            iss_k <= iss_k + 1'b1;
                        end
                        if (rem == '0) begin
                            w_en <= 1'b0;
                        end else begin
                            rem    <= rem - 1'b1;
                            w_addr <= w_addr + 1'b1;
                        end
                    end

                    if (rd_vld) begin
                        if (rd_k == K_BIAS) begin
                            score[rd_cls] <= score_val;
                            // Class 0 seeds the running max; afterwards only a
                            // strictly greater score moves it, so the lowest
                            // index keeps ties.
                            if ((rd_cls == '0) || (score_val > run_max)) begin
                                run_max <= score_val;
                                run_idx <= rd_cls;
                            end
                            if (rd_cls == IDX_LAST) begin
                                state <= CMP;
                            end
                        end else begin
                            acc <= mac_val;
                        end
                    end
                end

                CMP: begin
                    rd_vld <= 1'b0;
                    for (int c = 0; c < N_OUT; c++) begin
                        y[c] <= (score[c] == run_max);
                    end
                    class_idx <= run_idx;
                    max_score <= run_max;
                    out_valid <= 1'b1;
                    state     <= DONE;
                end

                DONE: begin
                    rd_vld <= 1'b0;
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dense_seq_ctrl.sv
// Testbench for dense_seq_ctrl: table of vectors with expected results,
// a synchronous weight-memory model, a reference score model and a
// scoreboard queue filled at accept time and drained at out_valid.
module tb_dense_seq_ctrl;

    localparam int N_IN   = 20;
    localparam int N_OUT  = 10;
    localparam int X_W    = 6;
    localparam int W_W    = 8;
    localparam int ACC_W  = 19;
    localparam int WPC    = N_IN + 1;
    localparam int TOTAL  = N_OUT * WPC;
    localparam int ADDR_W = $clog2(TOTAL);
    localparam int IDX_W  = $clog2(N_OUT);
    localparam int LAT    = TOTAL + 2;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  in_valid;
    logic                  in_ready;
    logic [N_IN*X_W-1:0]   x_flat;
    logic                  w_en;
    logic [ADDR_W-1:0]     w_addr;
    logic [W_W-1:0]        w_data = '0;
    logic                  out_valid;
    logic                  out_ready;
    logic [N_OUT-1:0]      y;
    logic [IDX_W-1:0]      class_idx;
    logic [ACC_W-1:0]      max_score;
    logic                  busy;

    dense_seq_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x_flat    (x_flat),
        .w_en      (w_en),
        .w_addr    (w_addr),
        .w_data    (w_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .class_idx (class_idx),
        .max_score (max_score),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    logic [W_W-1:0] wmem [TOTAL];

    // Synchronous weight memory: data one cycle after the address.
    always @(posedge clk) begin
        if (w_en) w_data <= wmem[w_addr];
    end

    typedef struct {
        int               mode;
        bit               use_model;
        logic [N_OUT-1:0] y;
        int               idx;
        int               mx;
        int               hold;
    } vec_t;

    typedef struct {
        logic [N_OUT-1:0] y;
        int               idx;
        int               mx;
    } exp_t;

    vec_t tbl [8];
    exp_t sbq [$];
    int   xv  [N_IN];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string nm, input longint act, input longint expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, expv);
        end
    endtask

    task automatic setup(input int mode);
        for (int k = 0; k < N_IN; k++) xv[k] = 0;
        for (int i = 0; i < TOTAL; i++) wmem[i] = '0;
        case (mode)
            1: for (int c = 0; c < N_OUT; c++) wmem[c*WPC+N_IN] = W_W'(c);
            2: for (int c = 0; c < N_OUT; c++) wmem[c*WPC+N_IN] = 8'd5;
            3: begin
                for (int k = 0; k < N_IN; k++) xv[k] = 63;
                for (int c = 0; c < N_OUT; c++)
                    for (int k = 0; k < N_IN; k++)
                        wmem[c*WPC+k] = (c == 3) ? 8'h7f : 8'h80;
            end
            4: begin
                for (int k = 0; k < N_IN; k++) xv[k] = $urandom_range(0, 63);
                for (int i = 0; i < TOTAL; i++) wmem[i] = W_W'($urandom);
            end
            5: begin
                for (int k = 0; k < N_IN; k++) xv[k] = 63;
                for (int i = 0; i < TOTAL; i++) wmem[i] = 8'h80;
            end
            6: begin
                for (int k = 0; k < N_IN; k++) xv[k] = 1;
                for (int c = 0; c < N_OUT; c++)
                    wmem[c*WPC+N_IN] = (c == 2 || c == 7) ? 8'h01 : 8'hff;
            end
            default: ;
        endcase
        for (int k = 0; k < N_IN; k++) x_flat[k*X_W +: X_W] = X_W'(xv[k]);
    endtask

    // Reference: full-precision sum per class, then reduced to ACC_W bits.
    function automatic exp_t model();
        exp_t e;
        logic signed [ACC_W-1:0] s [N_OUT];
        logic signed [ACC_W-1:0] best;
        int sum;
        for (int c = 0; c < N_OUT; c++) begin
            sum = 0;
            for (int k = 0; k < N_IN; k++)
                sum += xv[k] * int'($signed(wmem[c*WPC+k]));
            sum += int'($signed(wmem[c*WPC+N_IN]));
            s[c] = sum[ACC_W-1:0];
        end
        best  = s[0];
        e.idx = 0;
        for (int c = 1; c < N_OUT; c++) begin
            if (s[c] > best) begin
                best  = s[c];
                e.idx = c;
            end
        end
        e.mx = best;
        for (int c = 0; c < N_OUT; c++) e.y[c] = (s[c] == best);
        return e;
    endfunction

    task automatic run_vec(input vec_t v);
        exp_t e;
        exp_t got;
        int edges, wcnt, nexp, first_w, last_w;
        bit addr_ok, stable_ok;
        logic [N_OUT-1:0] sy;
        logic [IDX_W-1:0] si;
        logic [ACC_W-1:0] sm;

        setup(v.mode);
        if (v.use_model) e = model();
        else begin
            e.y = v.y; e.idx = v.idx; e.mx = v.mx;
        end

        @(negedge clk);
        chk("in_ready_idle", in_ready, 1);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        sbq.push_back(e);

        edges = 0; wcnt = 0; nexp = 0; first_w = -1; last_w = -1; addr_ok = 1'b1;
        while (!out_valid && edges < 2*LAT) begin
            if (w_en) begin
                if (int'(w_addr) != nexp) addr_ok = 1'b0;
                if (first_w < 0) first_w = edges;
                last_w = edges;
                nexp++;
                wcnt++;
            end
            @(posedge clk);
            #1;
            edges++;
        end

        chk("latency", edges, LAT);
        chk("w_en_cycles", wcnt, TOTAL);
        chk("w_addr_contig", addr_ok, 1);
        chk("w_en_first", first_w, 0);
        chk("w_en_span", last_w - first_w, TOTAL - 1);
        chk("w_en_low_done", w_en, 0);
        chk("in_ready_done", in_ready, 0);

        if (sbq.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL scoreboard: got empty queue expected entry");
        end else begin
            got = sbq.pop_front();
            chk("y", y, got.y);
            chk("class_idx", class_idx, got.idx);
            chk("max_score", $signed(max_score), got.mx);
            chk("y_nonzero", (y != '0), 1);
        end

        sy = y; si = class_idx; sm = max_score; stable_ok = 1'b1;
        for (int h = 0; h < v.hold; h++) begin
            @(negedge clk);
            in_valid = h[0];
            x_flat   = {4{30'($urandom)}};
            @(posedge clk);
            #1;
            if (y !== sy || class_idx !== si || max_score !== sm ||
                !out_valid || in_ready || w_en || !busy)
                stable_ok = 1'b0;
        end
        if (v.hold > 0) chk("hold_stable", stable_ok, 1);

        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("release_out_valid", out_valid, 0);
        chk("release_in_ready", in_ready, 1);
        chk("release_busy", busy, 0);
        chk("release_w_en", w_en, 0);
    endtask

    initial begin
        vec_t r;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        x_flat    = '0;

        tbl[0] = '{1, 1'b0, 10'b1000000000, 9, 9, 0};
        tbl[1] = '{2, 1'b0, 10'b1111111111, 0, 5, 0};
        tbl[2] = '{3, 1'b0, 10'b0000001000, 3, 160020, 0};
        tbl[3] = '{5, 1'b0, 10'b1111111111, 0, -161408, 3};
        tbl[4] = '{6, 1'b0, 10'b0010000100, 2, 1, 0};
        tbl[5] = '{4, 1'b1, 10'b0, 0, 0, 50};
        tbl[6] = '{4, 1'b1, 10'b0, 0, 0, 1};
        tbl[7] = '{4, 1'b1, 10'b0, 0, 0, 2};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_w_en", w_en, 0);
        chk("rst_w_addr", w_addr, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_y", y, 0);
        chk("rst_class_idx", class_idx, 0);
        chk("rst_max_score", max_score, 0);
        chk("rst_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) run_vec(tbl[i]);

        // Reset in the middle of RUN with another vector pending.
        setup(4);
        @(negedge clk);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        x_flat = {4{30'($urandom)}};
        repeat (100) @(posedge clk);
        #1;
        chk("midrun_w_en_before", w_en, 1);
        rst = 1'b1;
        #1;
        chk("midrun_rst_w_en", w_en, 0);
        chk("midrun_rst_out_valid", out_valid, 0);
        chk("midrun_rst_in_ready", in_ready, 1);
        chk("midrun_rst_busy", busy, 0);
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        r = '{4, 1'b1, 10'b0, 0, 0, 0};
        run_vec(r);
        r = '{1, 1'b0, 10'b1000000000, 9, 9, 0};
        run_vec(r);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
